// File: rtl/grid_xform_pkg.sv
// Shared types and command codes for the grid transform block.
package grid_xform_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_OP   = 2'd2,
    ST_DUMP = 2'd3
  } state_e;

  localparam logic [3:0] MODE_FINISH    = 4'd0;
  localparam logic [3:0] MODE_MIRROR_LR = 4'd1;
  localparam logic [3:0] MODE_MIRROR_TB = 4'd2;
  localparam logic [3:0] MODE_ROT_CCW   = 4'd3;
  localparam logic [3:0] MODE_ROT_CW    = 4'd4;
  localparam logic [3:0] MODE_COL_INC   = 4'd5;
  localparam logic [3:0] MODE_COL_DEC   = 4'd6;
  localparam logic [3:0] MODE_ROW_INC   = 4'd7;
  localparam logic [3:0] MODE_TRANSPOSE = 4'd8;

  // Codes at or above this bound are reserved.
  localparam logic [3:0] MODE_RSVD_MIN  = 4'd9;

endpackage

// File: rtl/grid_sat_step.sv
// W-bit saturating increment / decrement, purely combinational.
module grid_sat_step #(
  parameter int W = 3
) (
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic [W-1:0] res_o
);

  always_comb begin
    res_o = val_i;
    if (dec_i) begin
      if (val_i != '0) res_o = val_i - W'(1);
    end else begin
      if (val_i != '1) res_o = val_i + W'(1);
    end
  end

endmodule

// File: rtl/grid_xform.sv
// N x N grid loader / transformer / streamer: load row-major, apply single-cycle
// whole-grid commands, then stream the result out with a valid/ready handshake.
module grid_xform
  import grid_xform_pkg::*;
#(
  parameter  int N  = 3,
  parameter  int W  = 3,
  localparam int SW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = $clog2(N * N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  input  logic          mode_valid,
  input  logic [3:0]    mode,
  input  logic [SW-1:0] sel,
  output logic          mode_err,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic          busy
);

  localparam int NN = N * N;
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CW-1:0] LAST = CW'(NN - 1);

  state_e                 state_q, state_d;
  logic [CW-1:0]          load_cnt_q, load_cnt_d;
  logic [CW-1:0]          dump_cnt_q, dump_cnt_d;
  logic [NN-1:0][W-1:0]   grid_q, grid_d, xf;
  logic                   mode_err_q, mode_err_d;
  logic                   sel_bad, code_bad;
  logic [W-1:0]           rd_data;

  assign sel_bad  = ({1'b0, sel} >= (SW + 1)'(N));
  assign code_bad = (mode >= MODE_RSVD_MIN) ||
                    (sel_bad && ((mode == MODE_COL_INC) || (mode == MODE_COL_DEC) ||
                                 (mode == MODE_ROW_INC)));

  // Next-grid candidate for every element; all reads come from the current grid.
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      localparam int IDX    = r * N + c;
      localparam int SRC_LR = r * N + (N - 1 - c);
      localparam int SRC_TB = (N - 1 - r) * N + c;
      localparam int SRC_CC = c * N + (N - 1 - r);
      localparam int SRC_CW = (N - 1 - c) * N + r;
      localparam int SRC_TR = c * N + r;
      localparam logic [SW-1:0] RSEL = SW'(r);
      localparam logic [SW-1:0] CSEL = SW'(c);

      logic [W-1:0] stp_val;
      logic [W-1:0] nv;

      grid_sat_step #(.W(W)) u_step (
        .val_i (grid_q[IDX]),
        .dec_i (mode == MODE_COL_DEC),
        .res_o (stp_val)
      );

      always_comb begin
        nv = grid_q[IDX];
        case (mode)
          MODE_MIRROR_LR: nv = grid_q[SRC_LR];
          MODE_MIRROR_TB: nv = grid_q[SRC_TB];
          MODE_ROT_CCW:   nv = grid_q[SRC_CC];
          MODE_ROT_CW:    nv = grid_q[SRC_CW];
          MODE_COL_INC,
          MODE_COL_DEC:   if (sel == CSEL) nv = stp_val;
          MODE_ROW_INC:   if (sel == RSEL) nv = stp_val;
          MODE_TRANSPOSE: nv = grid_q[SRC_TR];
          default:        nv = grid_q[IDX];
        endcase
      end

      assign xf[IDX] = nv;
    end
  end

  assign rd_data   = grid_q[dump_cnt_q[IW-1:0]];
  assign busy      = (state_q != ST_IDLE);
  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_DUMP);
  assign out_last  = out_valid && (dump_cnt_q == LAST);
  assign out_data  = out_valid ? rd_data : '0;
  assign mode_err  = mode_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      load_cnt_q <= '0;
      dump_cnt_q <= '0;
      grid_q     <= '0;
      mode_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      dump_cnt_q <= dump_cnt_d;
      grid_q     <= grid_d;
      mode_err_q <= mode_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    dump_cnt_d = dump_cnt_q;
    grid_d     = grid_q;
    mode_err_d = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_LOAD;
      ST_LOAD: begin
        if (in_valid) begin
          grid_d[load_cnt_q[IW-1:0]] = in_data;
          if (load_cnt_q == LAST) begin
            load_cnt_d = '0;
            state_d    = ST_OP;
          end else begin
            load_cnt_d = load_cnt_q + CW'(1);
          end
        end
      end
      ST_OP: begin
        if (mode_valid) begin
          if (code_bad)                 mode_err_d = 1'b1;
          else if (mode == MODE_FINISH) state_d    = ST_DUMP;
          else                          grid_d     = xf;
        end
      end
      ST_DUMP: begin
        if (out_ready) begin
          if (dump_cnt_q == LAST) begin
            dump_cnt_d = '0;
            grid_d     = '0;
            state_d    = ST_IDLE;
          end else begin
            dump_cnt_d = dump_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_grid_xform.sv
// Bench for grid_xform: directed vector table, reset corner cases and randomized
// command streams checked against a 2-D array model of the grid.
module tb_grid_xform;

  localparam int N  = 3;
  localparam int W  = 3;
  localparam int NN = N * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         mode_valid = 1'b0;
  logic [3:0]   mode = '0;
  logic [1:0]   sel = '0;
  logic         mode_err;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_ready = 1'b0;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  grid_xform #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mode_valid (mode_valid),
    .mode       (mode),
    .sel        (sel),
    .mode_err   (mode_err),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  typedef struct packed {
    logic [3:0]      m0;
    logic [1:0]      s0;
    logic            e0;
    logic [3:0]      m1;
    logic [1:0]      s1;
    logic            e1;
    logic [1:0]      ncmd;
    logic [3:0]      stall;
    logic [NN*W-1:0] exp;
  } vec_t;

  vec_t vt[10];
  int   ld[NN];
  int   exp_out[NN];
  int   mg[N][N];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [NN*W-1:0] pk(int a0, int a1, int a2, int a3, int a4,
                                          int a5, int a6, int a7, int a8);
    return {W'(a8), W'(a7), W'(a6), W'(a5), W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  function automatic vec_t mkv(int m0, int s0, int e0, int m1, int s1, int e1,
                               int nc, int st, logic [NN*W-1:0] ex);
    vec_t v;
    v.m0 = 4'(m0); v.s0 = 2'(s0); v.e0 = 1'(e0);
    v.m1 = 4'(m1); v.s1 = 2'(s1); v.e1 = 1'(e1);
    v.ncmd = 2'(nc); v.stall = 4'(st); v.exp = ex;
    return v;
  endfunction

  // Reference model: grid as a 2-D array, commands written straight from the rules.
  function automatic int model_cmd(int code, int s);
    int t[N][N];
    int mx;
    mx = (1 << W) - 1;
    if (code >= 9 || (code >= 5 && code <= 7 && s >= N)) return 1;
    t = mg;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        case (code)
          1: mg[r][c] = t[r][N-1-c];
          2: mg[r][c] = t[N-1-r][c];
          3: mg[r][c] = t[c][N-1-r];
          4: mg[r][c] = t[N-1-c][r];
          5: if (c == s) mg[r][c] = (t[r][c] >= mx) ? mx : t[r][c] + 1;
          6: if (c == s) mg[r][c] = (t[r][c] <= 0) ? 0 : t[r][c] - 1;
          7: if (r == s) mg[r][c] = (t[r][c] >= mx) ? mx : t[r][c] + 1;
          8: mg[r][c] = t[c][r];
          default: mg[r][c] = t[r][c];
        endcase
      end
    end
    return 0;
  endfunction

  task automatic load_n(input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      int t;
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = W'(ld[k]);
      t = 0;
      while (!in_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        chk("load_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_cmd(input int code, input int s, input int exp_err);
    mode_valid = 1'b1;
    mode       = 4'(code);
    sel        = 2'(s);
    @(negedge clk);
    mode_valid = 1'b0;
    chk("mode_err", int'(mode_err), exp_err);
    if (exp_err != 0) begin
      @(negedge clk);
      chk("mode_err_pulse", int'(mode_err), 0);
    end
  endtask

  task automatic dump_check(input int stall_idx);
    int idx;
    int t;
    int held;
    idx = 0; t = 0; held = 0;
    while (idx < NN && t < 400) begin
      if (idx == stall_idx && held < 5) begin
        out_ready = 1'b0;
        held++;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      chk("dump_valid", int'(out_valid), 1);
      chk("dump_data", int'(out_data), exp_out[idx]);
      chk("dump_last", int'(out_last), (idx == NN - 1) ? 1 : 0);
      if (out_valid && out_ready) idx++;
      @(negedge clk);
      t++;
    end
    if (idx < NN) chk("dump_timeout", idx, NN);
    out_ready = 1'b0;
    chk("dump_end_valid", int'(out_valid), 0);
    chk("dump_end_busy", int'(busy), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_last"}, int'(out_last), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
    chk({tag, "_mode_err"}, int'(mode_err), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  function automatic void set_base_load();
    for (int k = 0; k < NN; k++) ld[k] = (k == NN - 1) ? 7 : k;
  endfunction

  initial begin
    vt[0] = mkv(3, 0, 0, 0, 0, 0, 1, 15, pk(2, 5, 7, 1, 4, 7, 0, 3, 6));
    vt[1] = mkv(1, 0, 0, 0, 0, 0, 1, 15, pk(2, 1, 0, 5, 4, 3, 7, 7, 6));
    vt[2] = mkv(5, 2, 0, 5, 2, 0, 2, 15, pk(0, 1, 4, 3, 4, 7, 6, 7, 7));
    vt[3] = mkv(2, 0, 0, 0, 0, 0, 1, 15, pk(6, 7, 7, 3, 4, 5, 0, 1, 2));
    vt[4] = mkv(4, 0, 0, 0, 0, 0, 1, 15, pk(6, 3, 0, 7, 4, 1, 7, 5, 2));
    vt[5] = mkv(8, 0, 0, 0, 0, 0, 1, 15, pk(0, 3, 6, 1, 4, 7, 2, 5, 7));
    vt[6] = mkv(6, 0, 0, 7, 1, 0, 2, 15, pk(0, 1, 2, 3, 5, 6, 5, 7, 7));
    vt[7] = mkv(9, 0, 1, 7, 3, 1, 2, 15, pk(0, 1, 2, 3, 4, 5, 6, 7, 7));
    vt[8] = mkv(3, 0, 0, 4, 0, 0, 2, 15, pk(0, 1, 2, 3, 4, 5, 6, 7, 7));
    vt[9] = mkv(0, 0, 0, 0, 0, 0, 0, 3,  pk(0, 1, 2, 3, 4, 5, 6, 7, 7));

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("busy_after_reset", int'(busy), 1);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      set_base_load();
      load_n(NN, (i % 2) == 1);
      chk("op_busy", int'(busy), 1);
      chk("op_in_ready", int'(in_ready), 0);
      if (vt[i].ncmd >= 1) send_cmd(int'(vt[i].m0), int'(vt[i].s0), int'(vt[i].e0));
      if (vt[i].ncmd >= 2) send_cmd(int'(vt[i].m1), int'(vt[i].s1), int'(vt[i].e1));
      send_cmd(0, 0, 0);
      for (int k = 0; k < NN; k++) exp_out[k] = int'(vt[i].exp[k*W +: W]);
      dump_check(int'(vt[i].stall));
    end

    // Reset after four loaded elements, then a clean full load
    set_base_load();
    load_n(4, 1'b0);
    chk("mid_load_ready", int'(in_ready), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_mid_load");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NN; k++) ld[k] = (k * 5 + 1) % 8;
    load_n(NN, 1'b0);
    send_cmd(0, 0, 0);
    for (int k = 0; k < NN; k++) exp_out[k] = ld[k];
    dump_check(-1);

    // Reset while streaming out
    set_base_load();
    load_n(NN, 1'b0);
    send_cmd(0, 0, 0);
    chk("pre_rst_dump_valid", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_mid_dump");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized command streams against the model
    for (int it = 0; it < 30; it++) begin
      int ncmd;
      for (int k = 0; k < NN; k++) ld[k] = $urandom_range(0, (1 << W) - 1);
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) mg[r][c] = ld[r*N + c];
      load_n(NN, 1'b1);
      ncmd = $urandom_range(1, 6);
      for (int j = 0; j < ncmd; j++) begin
        int code;
        int s;
        int e;
        code = $urandom_range(1, 15);
        s    = $urandom_range(0, 3);
        e    = model_cmd(code, s);
        send_cmd(code, s, e);
      end
      send_cmd(0, 0, 0);
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) exp_out[r*N + c] = mg[r][c];
      dump_check(-1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grid_xform.md
GRID_XFORM -- requirements
Module: grid_xform

Interface
REQ-001 SHALL have parameter N, default 3, meaning grid side length (N>=1, N*N elements).
REQ-002 SHALL have parameter W, default 3, meaning element width in bits.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  load element valid.
REQ-006 SHALL have port in_data  input  W  load element, row-major order.
REQ-007 SHALL have port in_ready  output  1  block accepts a load element.
REQ-008 SHALL have port mode_valid  input  1  mode command valid.
REQ-009 SHALL have port mode  input  4  command code.
REQ-010 SHALL have port sel  input  clog2(N) (min 1)  row/column index for the column and row commands.
REQ-011 SHALL have port mode_err  output  1  one-cycle pulse on a reserved code or sel>=N.
REQ-012 SHALL have port out_valid  output  1  output element valid.
REQ-013 SHALL have port out_data  output  W  output element, row-major order.
REQ-014 SHALL have port out_last  output  1  asserted with the final (N*N-th) element.
REQ-015 SHALL have port out_ready  input  1  downstream accepts the element.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, LOAD, OP, DUMP; IDLE->LOAD unconditionally on the next clock.
REQ-018 SHALL assert in_ready only in LOAD; each cycle with in_valid&&in_ready SHALL store in_data at index load_cnt and increment load_cnt.
REQ-019 SHALL go LOAD->OP on acceptance of element N*N-1; in_valid low SHALL hold without losing the count.
REQ-020 SHALL, in OP, apply one command per cycle with mode_valid high, and ignore mode_valid outside OP.
REQ-021 Codes: 0 finish (OP->DUMP); 1 mirror left-right; 2 mirror top-bottom; 3 rotate CCW, new(r,c)=old(c,N-1-r); 4 rotate CW, new(r,c)=old(N-1-c,r); 5 column sel +1; 6 column sel -1; 7 row sel +1; 8 transpose.
REQ-022 SHALL saturate +1 at 2^W-1 and -1 at 0; elements outside the addressed row or column SHALL be unchanged.
REQ-023 Codes 9-15, or codes 5-7 with sel>=N, SHALL leave the grid unchanged and pulse mode_err for one cycle.
REQ-024 SHALL apply every command to the whole grid in a single cycle, with all reads from the pre-command grid.
REQ-025 SHALL, in DUMP, present element 0 with out_valid on the first DUMP cycle, and advance to the next element only on out_valid&&out_ready.
REQ-026 SHALL hold out_data, out_valid and out_last stable while out_ready is low.
REQ-027 SHALL go DUMP->IDLE on the handshake of the last element, clear the grid to 0, and drop out_valid on the next cycle.
REQ-028 With N=1, rotate, mirror and transpose SHALL be identity operations.
REQ-029 SHALL size the counters as clog2(N*N+1) bits with no wrap-around beyond N*N-1.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, all grid elements 0, all counters 0, and in_ready, out_valid, out_last, out_data, mode_err and busy to 0.
REQ-031 Reset mid-LOAD, mid-OP or mid-DUMP SHALL discard the partial grid; the next load SHALL start at index 0.

Structure
REQ-032 Package grid_xform_pkg SHALL hold the state enum, the 4-bit mode code constants and the reserved-code bound.
REQ-033 Sub-module grid_sat_step (W-bit saturating +1/-1, combinational) SHALL be instantiated per element or per lane.
REQ-034 The grid SHALL be a flat register array of N*N by W bits; there SHALL be no memory macro.

Verification
REQ-035 N=3, W=3, load 0,1,2,3,4,5,6,7,7; mode 3; mode 0 -> out 2,5,7,1,4,7,0,3,6, with out_last on the 9th element.
REQ-036 Same load; mode 1; mode 0 -> out 2,1,0,5,4,3,7,7,6.
REQ-037 Same load; mode 5 with sel=2 twice; mode 0 -> col2 = 4,7,7 (saturated); out 0,1,4,3,4,7,6,7,7.
REQ-038 Same load; mode 9 -> mode_err one-cycle pulse, grid unchanged; mode 7 with sel=3 -> mode_err pulse.
REQ-039 During DUMP, hold out_ready low for 5 cycles after element 3 -> out_data stays 3 and no element is skipped or duplicated.
REQ-040 Assert rst_n low after 4 loaded elements -> all outputs 0 at once; the next full load of 9 elements dumps correctly.
